// File: rtl/register_file.sv
// register_file: parameterised multi-register storage with one write port and
// one registered read port (1-cycle latency, write-first bypass).
// Optional build macro REGISTER_FILE_ZERO_REG_EN hardwires register 0 to zero.
// Reset is asynchronous, active-low, and clears all storage and read outputs.
module register_file #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 32,
  parameter int ADDR_WIDTH = 5
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  write_enable,
  input  logic [ADDR_WIDTH-1:0] write_address,
  input  logic [DATA_WIDTH-1:0] write_data,
  input  logic                  read_enable,
  input  logic [ADDR_WIDTH-1:0] read_address,
  output logic [DATA_WIDTH-1:0] read_data,
  output logic                  read_data_valid
);

  localparam int unsigned DEPTH_U = DEPTH;

  logic [DATA_WIDTH-1:0] regs_q [DEPTH];

  logic                  wr_in_range;
  logic                  rd_in_range;
  logic                  wr_allowed;
  logic                  rd_forced_zero;
  logic                  wr_hit;
  logic                  bypass;
  logic [DATA_WIDTH-1:0] rd_word;

  logic [DATA_WIDTH-1:0] read_data_d;
  logic [DATA_WIDTH-1:0] read_data_q;
  logic                  read_valid_d;
  logic                  read_valid_q;

  // Addresses at or beyond DEPTH do not map to storage.
  assign wr_in_range = (32'(write_address) < DEPTH_U);
  assign rd_in_range = (32'(read_address) < DEPTH_U);

`ifdef REGISTER_FILE_ZERO_REG_EN
  // Register 0 is a constant zero: never written, always reads back zero.
  assign wr_allowed     = wr_in_range && (write_address != '0);
  assign rd_forced_zero = (read_address == '0);
`else
  assign wr_allowed     = wr_in_range;
  assign rd_forced_zero = 1'b0;
`endif

  assign wr_hit = write_enable && wr_allowed;
  assign bypass = wr_hit && (write_address == read_address);

  // Select the word a read on this edge returns, forwarding same-edge write data.
  always_comb begin
    rd_word = '0;
    if (rd_in_range && !rd_forced_zero) begin
      if (bypass) begin
        rd_word = write_data;
      end else begin
        rd_word = regs_q[read_address];
      end
    end
  end

  // Next read result: load on a read, otherwise hold the last value; valid tracks read_enable.
  always_comb begin
    read_data_d  = read_data_q;
    read_valid_d = 1'b0;
    if (read_enable) begin
      read_data_d  = rd_word;
      read_valid_d = 1'b1;
    end
  end

  // Storage array: cleared on reset, single-word update on an accepted write.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int unsigned i = 0; i < DEPTH_U; i++) begin
        regs_q[i] <= '0;
      end
    end else if (wr_hit) begin
      regs_q[write_address] <= write_data;
    end
  end

  // Registered read port; reset discards any in-flight result.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      read_data_q  <= '0;
      read_valid_q <= 1'b0;
    end else begin
      read_data_q  <= read_data_d;
      read_valid_q <= read_valid_d;
    end
  end

  assign read_data       = read_data_q;
  assign read_data_valid = read_valid_q;

endmodule

// File: tb/tb_register_file.sv
// Directed self-checking bench for register_file (default build, DEPTH below
// 2**ADDR_WIDTH so out-of-range addresses are exercised).
module tb_register_file;

  localparam int DW = 32;
  localparam int DP = 24;
  localparam int AW = 5;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          write_enable;
  logic [AW-1:0] write_address;
  logic [DW-1:0] write_data;
  logic          read_enable;
  logic [AW-1:0] read_address;
  logic [DW-1:0] read_data;
  logic          read_data_valid;

  int total = 0;
  int bad   = 0;

  register_file #(
    .DATA_WIDTH(DW),
    .DEPTH     (DP),
    .ADDR_WIDTH(AW)
  ) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .write_enable   (write_enable),
    .write_address  (write_address),
    .write_data     (write_data),
    .read_enable    (read_enable),
    .read_address   (read_address),
    .read_data      (read_data),
    .read_data_valid(read_data_valid)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic we, input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                       input logic re, input logic [AW-1:0] ra);
    write_enable  = we;
    write_address = wa;
    write_data    = wd;
    read_enable   = re;
    read_address  = ra;
  endtask

  initial begin
    reset_n = 1'b0;
    drive(1'b1, 5'd4, 32'hCAFE_0004, 1'b1, 5'd4);
    tick();
    tick();
    // Reset state: requests presented during reset are discarded.
    check("rst_data",  read_data, 32'h0);
    check("rst_valid", {31'h0, read_data_valid}, 32'h0);

    reset_n = 1'b1;
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0);
    tick();
    check("idle_valid", {31'h0, read_data_valid}, 32'h0);

    // Write then read addr 5.
    drive(1'b1, 5'd5, 32'hA5A5_A5A5, 1'b0, 5'd0); tick();
    drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd5);         tick();
    check("rd5_data",  read_data, 32'hA5A5_A5A5);
    check("rd5_valid", {31'h0, read_data_valid}, 32'h1);

    // Write then read addr 10.
    drive(1'b1, 5'd10, 32'hDEAD_BEEF, 1'b0, 5'd0); tick();
    drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd10);         tick();
    check("rd10_data",  read_data, 32'hDEAD_BEEF);
    check("rd10_valid", {31'h0, read_data_valid}, 32'h1);

    // Register discarded during reset reads back zero.
    drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd4); tick();
    check("rd4_discarded", read_data, 32'h0);

    // Address 31 (out of range for DEPTH 24) returns zero with valid.
    drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd31); tick();
    check("rd31_data",  read_data, 32'h0);
    check("rd31_valid", {31'h0, read_data_valid}, 32'h1);

    // Overwrite of addr 15.
    drive(1'b1, 5'd15, 32'h1234_5678, 1'b0, 5'd0); tick();
    drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd15);         tick();
    check("rd15_first", read_data, 32'h1234_5678);
    drive(1'b1, 5'd15, 32'hFFFF_FFFF, 1'b0, 5'd0); tick();
    drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd15);         tick();
    check("rd15_second", read_data, 32'hFFFF_FFFF);

    // Same-edge write/read of addr 7 (bypass), then idle holds data.
    drive(1'b1, 5'd7, 32'h0BAD_F00D, 1'b1, 5'd7); tick();
    check("bypass7_data",  read_data, 32'h0BAD_F00D);
    check("bypass7_valid", {31'h0, read_data_valid}, 32'h1);
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd5); tick();
    check("hold_valid", {31'h0, read_data_valid}, 32'h0);
    check("hold_data",  read_data, 32'h0BAD_F00D);

    // Simultaneous read/write to different addresses.
    drive(1'b1, 5'd20, 32'h2020_2020, 1'b1, 5'd5); tick();
    check("diff_rd5", read_data, 32'hA5A5_A5A5);
    drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd20); tick();
    check("diff_rd20", read_data, 32'h2020_2020);

    // Back-to-back writes to the same address; last one wins.
    drive(1'b1, 5'd9, 32'h0000_0001, 1'b0, 5'd0); tick();
    drive(1'b1, 5'd9, 32'h0000_0002, 1'b0, 5'd0); tick();
    drive(1'b1, 5'd9, 32'h0000_0003, 1'b0, 5'd0); tick();
    drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd9);          tick();
    check("rd9_last", read_data, 32'h0000_0003);

    // Back-to-back reads on consecutive cycles.
    drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd5);  tick();
    check("b2b_rd5", read_data, 32'hA5A5_A5A5);
    drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd10); tick();
    check("b2b_rd10", read_data, 32'hDEAD_BEEF);
    drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd15); tick();
    check("b2b_rd15", read_data, 32'hFFFF_FFFF);

    // Last valid address, and out-of-range writes that must not alias.
    drive(1'b1, 5'd23, 32'h2323_2323, 1'b0, 5'd0); tick();
    drive(1'b1, 5'd24, 32'h2424_2424, 1'b0, 5'd0); tick();
    drive(1'b1, 5'd28, 32'h2828_2828, 1'b1, 5'd28); tick();
    check("oor_rd28_bypass", read_data, 32'h0);
    check("oor_rd28_valid", {31'h0, read_data_valid}, 32'h1);
    drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd23); tick();
    check("rd23_last", read_data, 32'h2323_2323);
    drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd0); tick();
    check("rd0_no_alias", read_data, 32'h0);
    drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd8); tick();
    check("rd8_no_alias", read_data, 32'h0);

    // Register 0 behaviour depends on build configuration.
    drive(1'b1, 5'd0, 32'h0000_0F0F, 1'b1, 5'd0); tick();
`ifdef REGISTER_FILE_ZERO_REG_EN
    check("reg0_bypass", read_data, 32'h0);
`else
    check("reg0_bypass", read_data, 32'h0000_0F0F);
`endif
    drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd0); tick();
`ifdef REGISTER_FILE_ZERO_REG_EN
    check("reg0_read", read_data, 32'h0);
`else
    check("reg0_read", read_data, 32'h0000_0F0F);
`endif

    // Reset mid-operation.
    drive(1'b1, 5'd3, 32'h1111_1111, 1'b0, 5'd0); tick();
    drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd3);         tick();
    check("rd3_pre_reset", read_data, 32'h1111_1111);
    #2;
    reset_n = 1'b0;
    #1;
    check("async_rst_data",  read_data, 32'h0);
    check("async_rst_valid", {31'h0, read_data_valid}, 32'h0);
    drive(1'b1, 5'd3, 32'h3333_3333, 1'b1, 5'd3);
    tick();
    check("held_rst_data",  read_data, 32'h0);
    check("held_rst_valid", {31'h0, read_data_valid}, 32'h0);
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0);
    #2;
    reset_n = 1'b1;
    tick();
    check("post_rst_valid", {31'h0, read_data_valid}, 32'h0);
    drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd3); tick();
    check("rd3_post_reset", read_data, 32'h0);
    check("rd3_post_valid", {31'h0, read_data_valid}, 32'h1);
    drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd5); tick();
    check("rd5_post_reset", read_data, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
